fwd_hazard_scoreboard: RTL

Parametrised forwarding and hazard unit that succeeds the fixed two-source, two-bypass forwarding logic. It keeps a shift-register scoreboard of in-flight register writers, one entry per pipeline stage past ID. From it the block derives:
- per-source bypass selects for EX-stage consumers, registered into EX;
- per-source bypass selects for ID-stage consumers (branch/jal/jalr), combinational;
- the load-use/branch stall.

It sits beside the ID/EX pipeline register and replaces the separate forwarding and stall logic.

---
 rtl/fwd_hazard_scoreboard.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_scoreboard.sv
// fwd_hazard_scoreboard
//
// Forwarding and hazard unit built around a shift-register scoreboard of
// in-flight register writers. Entry 0 is the instruction in EX, entry 1 MEM,
// entry DEPTH-1 WB. Each entry records {valid, rd, avail}, where avail is the
// scoreboard index at which the writer's result first appears on a bypass bus.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   id_valid          ID holds a real instruction
//   id_rs             NSRC packed source register numbers
//   id_rs_use         source i is read
//   id_rs_early       source i is consumed in ID (branch / jalr compare)
//   id_rd             destination register
//   id_regwrite       writes rd with an ALU / PC+4 result
//   id_memread        load that writes rd
//   flush             kill the instruction in ID
//   stall             hold PC and IF/ID, insert a bubble into EX
//   id_fwd_sel        combinational ID-stage bypass select per source
//   ex_fwd_sel        registered EX-stage bypass select per source
//   stall_cnt         saturating count of stall cycles
module fwd_hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int NSRC     = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2,
    parameter int SELW     = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [NSRC*REG_AW-1:0] id_rs,
    input  logic [NSRC-1:0]        id_rs_use,
    input  logic [NSRC-1:0]        id_rs_early,
    input  logic [REG_AW-1:0]      id_rd,
    input  logic                   id_regwrite,
    input  logic                   id_memread,
    input  logic                   flush,
    output logic                   stall,
    output logic [NSRC*SELW-1:0]   id_fwd_sel,
    output logic [NSRC*SELW-1:0]   ex_fwd_sel,
    output logic [31:0]            stall_cnt
);

    logic [DEPTH-1:0]  valid_r;
    logic [REG_AW-1:0] rd_r    [DEPTH];
    logic [SELW-1:0]   avail_r [DEPTH];

    logic [NSRC-1:0]      hazard_s;
    logic [NSRC*SELW-1:0] id_sel_s;
    logic [NSRC*SELW-1:0] ex_next_s;
    logic [REG_AW-1:0]    rs_s;
    logic                 hit_s;
    int                   k_s;
    int                   av_s;
    logic                 stall_s;
    logic                 issue_s;
    logic                 ins_valid_s;

    // Youngest-match search per source and hazard / select derivation
    always_comb begin
        hazard_s  = '0;
        id_sel_s  = '0;
        ex_next_s = '0;
        rs_s      = '0;
        hit_s     = 1'b0;
        k_s       = 0;
        av_s      = 0;
        for (int i = 0; i < NSRC; i++) begin
            rs_s  = id_rs[i*REG_AW +: REG_AW];
            hit_s = 1'b0;
            k_s   = 0;
            av_s  = 0;
            // Walk oldest to youngest so the smallest matching index wins.
            for (int j = DEPTH - 1; j >= 0; j--) begin
                if (valid_r[j] && (rd_r[j] == rs_s)) begin
                    hit_s = 1'b1;
                    k_s   = j;
                    av_s  = int'(avail_r[j]);
                end else begin
                    hit_s = hit_s;
                end
            end
            if (id_rs_use[i] && (rs_s != '0) && hit_s) begin
                if (id_rs_early[i]) begin
                    if (k_s < av_s) begin
                        hazard_s[i] = 1'b1;
                    end else begin
                        id_sel_s[i*SELW +: SELW] = SELW'(k_s);
                    end
                end else begin
                    // Late consumer meets the producer one stage further on.
                    if ((k_s + 1) < av_s) begin
                        hazard_s[i] = 1'b1;
                    end else if ((k_s + 1) <= (DEPTH - 1)) begin
                        ex_next_s[i*SELW +: SELW] = SELW'(k_s + 1);
                    end else begin
                        // Producer has retired: the register file holds it.
                        ex_next_s[i*SELW +: SELW] = '0;
                    end
                end
            end else begin
                hazard_s[i] = 1'b0;
            end
        end
    end

    // Stall, issue qualification and insertion validity
    always_comb begin
        stall_s     = id_valid && !flush && (|hazard_s);
        issue_s     = id_valid && !stall_s && !flush;
        ins_valid_s = issue_s && (id_regwrite || id_memread) && (id_rd != '0);
    end

    assign stall      = stall_s;
    assign id_fwd_sel = id_sel_s;

    // Scoreboard shift register: insert at index 0, retire at DEPTH-1
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                rd_r[j]    <= '0;
                avail_r[j] <= '0;
            end
        end else begin
            for (int j = DEPTH - 1; j > 0; j--) begin
                valid_r[j] <= valid_r[j-1];
                rd_r[j]    <= rd_r[j-1];
                avail_r[j] <= avail_r[j-1];
            end
            valid_r[0] <= ins_valid_s;
            rd_r[0]    <= id_rd;
            avail_r[0] <= id_memread ? SELW'(LOAD_LAT) : SELW'(1);
        end
    end

    // EX-stage select register; stalled or flushed slots carry a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_fwd_sel <= '0;
        end else if (issue_s) begin
            ex_fwd_sel <= ex_next_s;
        end else begin
            ex_fwd_sel <= '0;
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
        end else if (stall_s && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end else begin
            stall_cnt <= stall_cnt;
        end
    end

endmodule
